// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the RV immediate decode stage.
package imm_pkg;

    // Immediate format tag carried alongside every decoded entry.
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    // Major opcodes (instr[6:0]) that this stage recognises.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // Map an opcode to its immediate format. SYSTEM with funct3[2]=1 is a
    // CSR-immediate form when zimm decoding is enabled; otherwise SYSTEM
    // carries a plain I-type immediate (the CSR address).
    function automatic imm_fmt_e opcode_fmt(input logic [6:0] opcode,
                                            input logic       funct3_msb,
                                            input logic       en_zicsr);
        imm_fmt_e fmt;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            OP_SYSTEM:                fmt = (funct3_msb && en_zicsr) ? FMT_Z : FMT_I;
            default:                  fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

    // True for every opcode in the format table, including the
    // immediate-less REG and FENCE groups.
    function automatic logic opcode_known(input logic [6:0] opcode);
        logic known;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM,
            OP_REG, OP_FENCE: known = 1'b1;
            default:          known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational RV immediate extractor: instruction word in, extended
// immediate, format tag and illegal flag out.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    // 32-bit sign-correct views of each encoding; widened to XLEN below.
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [4:0]  zimm;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign zimm  = instr[19:15];

    // Classify the word: format from the opcode, illegal if the low bits
    // are not the 32-bit encoding marker or the opcode is unknown.
    always_comb begin
        fmt     = opcode_fmt(instr[6:0], instr[14], EN_ZICSR);
        illegal = (instr[1:0] != 2'b11) || !opcode_known(instr[6:0]);
    end

    // Select and extend the immediate. Sign extension comes from the
    // signed size cast; zimm is the only zero-extended field.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path
        // driven, so no latch is inferred when a new format is added.
        imm = '0;
        case (fmt)
            FMT_I:   imm = XLEN'($signed(imm_i));
            FMT_S:   imm = XLEN'($signed(imm_s));
            FMT_B:   imm = XLEN'($signed(imm_b));
            FMT_U:   imm = XLEN'($signed(imm_u));
            FMT_J:   imm = XLEN'($signed(imm_j));
            FMT_Z:   imm = XLEN'(zimm);
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode-stage immediate generator: decodes on the input path, then holds
// results in a main register (drives outputs) backed by a one-entry skid
// register so the stage keeps one word per clock under backpressure while
// in_ready stays a pure flop output.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_fmt_e        out_fmt,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    // Decoded view of the incoming word.
    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;

    imm_extract #(
        .XLEN     (XLEN),
        .EN_ZICSR (EN_ZICSR)
    ) u_extract (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // Main entry (visible on out_*).
    logic            main_valid_q,   main_valid_d;
    logic [XLEN-1:0] main_imm_q,     main_imm_d;
    imm_fmt_e        main_fmt_q,     main_fmt_d;
    logic [XLEN-1:0] main_pc_q,      main_pc_d;
    logic            main_illegal_q, main_illegal_d;

    // Skid entry (holds one decoded word while main is stalled).
    logic            skid_valid_q,   skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,     skid_imm_d;
    imm_fmt_e        skid_fmt_q,     skid_fmt_d;
    logic [XLEN-1:0] skid_pc_q,      skid_pc_d;
    logic            skid_illegal_q, skid_illegal_d;

    logic in_xfer;
    logic main_free;

    // Ready depends only on the skid flop, so out_ready never reaches in_ready.
    assign in_ready = !skid_valid_q;

    // A flush drops the word offered in the same cycle.
    assign in_xfer   = in_valid && in_ready && !flush;

    // Main can take a new entry when empty or when it drains this cycle.
    assign main_free = !main_valid_q || out_ready;

    // Next-state for main and skid: flush wins, then skid refills main
    // ahead of any new input to keep FIFO order.
    always_comb begin
        main_valid_d   = main_valid_q;
        main_imm_d     = main_imm_q;
        main_fmt_d     = main_fmt_q;
        main_pc_d      = main_pc_q;
        main_illegal_d = main_illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_fmt_d     = skid_fmt_q;
        skid_pc_d      = skid_pc_q;
        skid_illegal_d = skid_illegal_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // in_ready was low, so no input competes with the skid.
                main_valid_d   = 1'b1;
                main_imm_d     = skid_imm_q;
                main_fmt_d     = skid_fmt_q;
                main_pc_d      = skid_pc_q;
                main_illegal_d = skid_illegal_q;
                skid_valid_d   = 1'b0;
            end else if (in_xfer) begin
                main_valid_d   = 1'b1;
                main_imm_d     = dec_imm;
                main_fmt_d     = dec_fmt;
                main_pc_d      = in_pc;
                main_illegal_d = dec_illegal;
            end else begin
                main_valid_d   = 1'b0;
            end
        end else if (in_xfer) begin
            // Main is full and stalled: park the word in the skid.
            skid_valid_d   = 1'b1;
            skid_imm_d     = dec_imm;
            skid_fmt_d     = dec_fmt;
            skid_pc_d      = in_pc;
            skid_illegal_d = dec_illegal;
        end
    end

    // Main register and both valid flags; reset clears data too because
    // main drives the outputs directly.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of its neighbours regardless of statement order.
        if (reset) begin
            main_valid_q   <= 1'b0;
            main_imm_q     <= '0;
            main_fmt_q     <= FMT_NONE;
            main_pc_q      <= '0;
            main_illegal_q <= 1'b0;
            skid_valid_q   <= 1'b0;
        end else begin
            main_valid_q   <= main_valid_d;
            main_imm_q     <= main_imm_d;
            main_fmt_q     <= main_fmt_d;
            main_pc_q      <= main_pc_d;
            main_illegal_q <= main_illegal_d;
            skid_valid_q   <= skid_valid_d;
        end
    end

    // Skid payload storage.
    always_ff @(posedge clk) begin
        // NOTE: skid data is left unreset; it is never observed unless
        // skid_valid_q is set, so only the valid flag needs a reset.
        skid_imm_q     <= skid_imm_d;
        skid_fmt_q     <= skid_fmt_d;
        skid_pc_q      <= skid_pc_d;
        skid_illegal_q <= skid_illegal_d;
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_imm_q;
    assign out_fmt     = main_fmt_q;
    assign out_pc      = main_pc_q;
    assign out_illegal = main_illegal_q;

endmodule
